// File: rtl/rr_bus_scheduler.sv
// Burst-limited round-robin scheduler for a shared slave bus: one registered one-hot
// grant at a time, held until ack/withdraw/watchdog, with a one-cycle bus turnaround.
module rr_bus_scheduler #(
  parameter int HOSTS     = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [HOSTS-1:0]         req,
  input  logic [HOSTS-1:0]         host_en,
  input  logic                     ack_bus,
  output logic [HOSTS-1:0]         grant,
  output logic [$clog2(HOSTS)-1:0] grant_id,
  output logic                     bus_busy,
  output logic                     timeout_err,
  output logic [$clog2(HOSTS)-1:0] err_host
);

  localparam int IDW = $clog2(HOSTS);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam int TW  = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK = 2'd1;
  localparam logic [1:0] ST_RELEASE  = 2'd2;

  localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [BW-1:0]  BURST_MAX  = BW'(MAX_BURST);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST    = IDW'(HOSTS - 1);

  logic [1:0]       r_state;
  logic [IDW-1:0]   r_rrPtr;
  logic [BW-1:0]    r_burstCnt;
  logic [TW-1:0]    r_timer;
  logic [HOSTS-1:0] r_grant;
  logic [IDW-1:0]   r_grantId;
  logic             r_busBusy;
  logic             r_timeoutErr;
  logic [IDW-1:0]   r_errHost;

  logic [HOSTS-1:0] w_elig;
  logic             w_found;
  logic [IDW-1:0]   w_pick;
  logic [HOSTS-1:0] w_pickOneHot;
  logic             w_otherElig;
  logic             w_keep;
  logic [IDW-1:0]   w_nextPtr;
  logic [BW-1:0]    w_burstInc;

  assign w_elig = req & host_en;

  // Walk from the highest offset down so the host closest to r_rrPtr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = HOSTS - 1; k >= 0; k--) begin
      if (w_elig[IDW'((int'(r_rrPtr) + k) % HOSTS)]) begin
        w_found = 1'b1;
        w_pick  = IDW'((int'(r_rrPtr) + k) % HOSTS);
      end
    end
  end

  assign w_pickOneHot = {{(HOSTS-1){1'b0}}, 1'b1} << w_pick;
  assign w_otherElig  = |(w_elig & ~r_grant);
  assign w_nextPtr    = (r_grantId == ID_LAST) ? '0 : r_grantId + IDW'(1);
  assign w_burstInc   = (r_burstCnt == BURST_MAX) ? r_burstCnt : r_burstCnt + BW'(1);

  // The burst cap only bites when somebody else is actually waiting.
  assign w_keep = req[r_grantId] & host_en[r_grantId] &
                  ((r_burstCnt < BURST_LAST) | ~w_otherElig);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_rrPtr      <= '0;
      r_burstCnt   <= '0;
      r_timer      <= '0;
      r_grant      <= '0;
      r_grantId    <= '0;
      r_busBusy    <= 1'b0;
      r_timeoutErr <= 1'b0;
      r_errHost    <= '0;
    end else begin
      r_timeoutErr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant    <= w_pickOneHot;
            r_grantId  <= w_pick;
            r_busBusy  <= 1'b1;
            r_timer    <= '0;
            r_burstCnt <= '0;
            r_state    <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_bus) begin
            r_burstCnt <= w_burstInc;
            r_timer    <= '0;
            if (!w_keep) begin
              r_grant   <= '0;
              r_busBusy <= 1'b0;
              r_state   <= ST_RELEASE;
            end
          end else if (!req[r_grantId]) begin
            r_grant   <= '0;
            r_busBusy <= 1'b0;
            r_state   <= ST_RELEASE;
          end else if (r_timer == TIMER_LAST) begin
            r_timeoutErr <= 1'b1;
            r_errHost    <= r_grantId;
            r_grant      <= '0;
            r_busBusy    <= 1'b0;
            r_state      <= ST_RELEASE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_RELEASE: begin
          r_rrPtr <= w_nextPtr;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grantId;
  assign bus_busy    = r_busBusy;
  assign timeout_err = r_timeoutErr;
  assign err_host    = r_errHost;

endmodule

// File: tb/tb_rr_bus_scheduler.sv
// Directed bench for rr_bus_scheduler: expected grant order is queued as stimulus is
// applied and popped whenever a new grant appears; timing/boundary checks are inline.
module tb_rr_bus_scheduler;

  localparam int HOSTS     = 4;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] host_en;
  logic       ack_bus;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       bus_busy;
  logic       timeout_err;
  logic [1:0] err_host;

  int nChecks = 0;
  int nFails  = 0;
  int expQ[$];
  logic prevBusy = 1'b0;

  rr_bus_scheduler #(
    .HOSTS(HOSTS), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .host_en(host_en), .ack_bus(ack_bus),
    .grant(grant), .grant_id(grant_id), .bus_busy(bus_busy),
    .timeout_err(timeout_err), .err_host(err_host)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] e, input logic a);
    req     = r;
    host_en = e;
    ack_bus = a;
  endtask

  // Every rising edge of bus_busy is a fresh grant and must match the next queued host.
  always @(negedge clk) begin
    if (bus_busy && !prevBusy) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected_grant", 32'(grant), 32'd0);
      end else begin
        int exp;
        exp = expQ.pop_front();
        checkOutput("sb_grant_id", 32'(grant_id), 32'(exp));
        checkOutput("sb_grant_onehot", 32'(grant), 32'd1 << exp);
      end
    end
    prevBusy = bus_busy;
  end

  initial begin
    int run, gap, bursts, cyc;
    reset_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst_busy", 32'(bus_busy), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_err_host", 32'(err_host), 32'd0);
    reset_n = 1'b1;

    $display("[TB] test 1: all hosts requesting, ack every busy cycle");
    applyStimulus(4'b1111, 4'b1111, 1'b0);
    expQ.push_back(0); expQ.push_back(1); expQ.push_back(2);
    expQ.push_back(3); expQ.push_back(0);
    run = 0; gap = 0; bursts = 0; cyc = 0;
    while (bursts < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus_busy) begin
        if (run == 0 && bursts > 0) checkOutput("t1_gap", 32'(gap), 32'd2);
        run++;
        gap = 0;
        ack_bus = 1'b1;
      end else begin
        if (run > 0) begin
          checkOutput("t1_burst_len", 32'(run), 32'(MAX_BURST));
          bursts++;
          run = 0;
          if (bursts == 5) req = 4'b0000;
        end
        gap++;
        ack_bus = 1'b0;
      end
    end
    checkOutput("t1_burst_count", 32'(bursts), 32'd5);
    repeat (2) @(negedge clk);

    $display("[TB] test 2: host2 alone, ack every 2nd cycle");
    applyStimulus(4'b0100, 4'b1111, 1'b0);
    expQ.push_back(2);
    @(negedge clk);
    checkOutput("t2_latency", 32'(bus_busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      ack_bus = (i % 2 == 1);
      @(negedge clk);
      checkOutput("t2_busy", 32'(bus_busy), 32'd1);
    end
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    @(negedge clk);
    checkOutput("t2_withdraw_busy", 32'(bus_busy), 32'd0);
    checkOutput("t2_withdraw_err", 32'(timeout_err), 32'd0);
    @(negedge clk);

    $display("[TB] test 3: host0 never acked, watchdog abort");
    applyStimulus(4'b0001, 4'b1111, 1'b0);
    expQ.push_back(0);
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k < 16) begin
        checkOutput("t3_no_early_err", 32'(timeout_err), 32'd0);
      end else begin
        checkOutput("t3_timeout_err", 32'(timeout_err), 32'd1);
        checkOutput("t3_err_host", 32'(err_host), 32'd0);
        checkOutput("t3_release_busy", 32'(bus_busy), 32'd0);
      end
    end
    expQ.push_back(0);
    @(negedge clk);
    checkOutput("t3_pulse_width", 32'(timeout_err), 32'd0);
    checkOutput("t3_idle_busy", 32'(bus_busy), 32'd0);
    @(negedge clk);
    checkOutput("t3_regrant", 32'(bus_busy), 32'd1);
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] test 4: eligibility mask");
    applyStimulus(4'b0011, 4'b0010, 1'b0);
    expQ.push_back(1);
    @(negedge clk);
    checkOutput("t4_latency", 32'(bus_busy), 32'd1);
    @(negedge clk);
    applyStimulus(4'b0011, 4'b0011, 1'b0);
    expQ.push_back(0);
    repeat (2) @(negedge clk);
    checkOutput("t4_hold_id", 32'(grant_id), 32'd1);
    applyStimulus(4'b0001, 4'b0011, 1'b1);
    @(negedge clk);
    checkOutput("t4_release", 32'(bus_busy), 32'd0);
    ack_bus = 1'b0;
    @(negedge clk);
    checkOutput("t4_turnaround", 32'(bus_busy), 32'd0);
    @(negedge clk);
    checkOutput("t4_host0_granted", 32'(bus_busy), 32'd1);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("t4_en_drop_holds", 32'(bus_busy), 32'd1);
    end
    ack_bus = 1'b1;
    @(negedge clk);
    checkOutput("t4_en_drop_release", 32'(bus_busy), 32'd0);
    ack_bus = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("t4_masked_idle", 32'(bus_busy), 32'd0);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    @(negedge clk);

    $display("[TB] test 5: ack on the last watchdog cycle, then a real timeout");
    applyStimulus(4'b0100, 4'b1111, 1'b0);
    expQ.push_back(2);
    @(negedge clk);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k < 32) begin
        checkOutput("t5_no_err", 32'(timeout_err), 32'd0);
        checkOutput("t5_busy", 32'(bus_busy), 32'd1);
      end else begin
        checkOutput("t5_timeout_err", 32'(timeout_err), 32'd1);
        checkOutput("t5_err_host", 32'(err_host), 32'd2);
        checkOutput("t5_release_busy", 32'(bus_busy), 32'd0);
      end
      ack_bus = (k == 15);
      if (k == 32) req = 4'b0000;
    end
    repeat (2) @(negedge clk);
    checkOutput("t5_err_host_held", 32'(err_host), 32'd2);

    $display("[TB] test 6: reset while a grant is active");
    applyStimulus(4'b0001, 4'b1111, 1'b0);
    expQ.push_back(0);
    @(negedge clk);
    checkOutput("t6_granted", 32'(bus_busy), 32'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_grant", 32'(grant), 32'd0);
    checkOutput("t6_rst_busy", 32'(bus_busy), 32'd0);
    checkOutput("t6_rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("t6_rst_err_host", 32'(err_host), 32'd0);
    applyStimulus(4'b0000, 4'b1111, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(4'b1010, 4'b1111, 1'b0);
    expQ.push_back(1);
    expQ.push_back(3);
    @(negedge clk);
    checkOutput("t6_latency", 32'(bus_busy), 32'd1);
    applyStimulus(4'b1000, 4'b1111, 1'b1);
    @(negedge clk);
    checkOutput("t6_release", 32'(bus_busy), 32'd0);
    ack_bus = 1'b0;
    @(negedge clk);
    checkOutput("t6_turnaround", 32'(bus_busy), 32'd0);
    @(negedge clk);
    checkOutput("t6_host3_granted", 32'(grant), 32'b1000);
    applyStimulus(4'b0000, 4'b1111, 1'b1);
    @(negedge clk);
    ack_bus = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
